// File: rtl/addsub_pkg.sv
// Shared constants for the sign-magnitude add/subtract datapath: default width,
// timing-strobe indices, adder operand selection and a strobe-validity helper.
package addsub_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int NUM_STROBES   = 8;

    // Strobe indices as issued by the sequencing control unit.
    localparam int T_IDLE  = 0;  // operand load
    localparam int T_NEGB  = 1;  // negate B sign for subtraction
    localparam int T_TEST  = 2;  // S valid for branching
    localparam int T_ADD   = 3;  // magnitude add
    localparam int T_SUB   = 4;  // magnitude subtract (A + ~B + 1)
    localparam int T_CHECK = 5;  // E valid for branching
    localparam int T_COMP  = 6;  // ones' complement of A
    localparam int T_INC   = 7;  // increment A, flip sign

    typedef enum logic [1:0] {
        ADD_OP_B    = 2'd0,
        ADD_OP_NOTB = 2'd1,
        ADD_OP_ZERO = 2'd2
    } adder_sel_e;

    function automatic logic is_onehot(input logic [NUM_STROBES-1:0] t);
        return (t != '0) && ((t & (t - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/addsub_adder.sv
// Ripple-carry adder with carry-in; shared by the add, subtract and increment
// micro-operations of addsub_datapath.
module addsub_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic [W:0] carry;

    assign carry[0] = cin_i;

    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        assign sum_o[gi]    = a_i[gi] ^ b_i[gi] ^ carry[gi];
        assign carry[gi+1]  = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
    end

    assign cout_o = carry[W];

endmodule

// File: rtl/addsub_datapath.sv
// Sign-magnitude add/subtract datapath driven by one-hot timing strobes T[7:0].
// Optional macro ADDSUB_ZERO_FIX_EN forces a positive sign on a zero difference.
module addsub_datapath
    import addsub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_STROBES-1:0] T,
    input  logic                   load,
    input  logic [WIDTH:0]         a_in,
    input  logic [WIDTH:0]         b_in,
    output logic                   S,
    output logic                   E,
    output logic [WIDTH:0]         result,
    output logic                   ovf,
    output logic                   done,
    output logic                   onehot_err
);

    logic             as_q,   as_d;
    logic [WIDTH-1:0] a_q,    a_d;
    logic             bs_q,   bs_d;
    logic [WIDTH-1:0] b_q,    b_d;
    logic             e_q,    e_d;
    logic             avf_q,  avf_d;
    logic             done_q, done_d;
    logic             err_q,  err_d;

    logic             strobe_ok;
    adder_sel_e       add_sel;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    assign strobe_ok = is_onehot(T);

    // One adder serves T3 (A+B), T4 (A+~B+1) and T7 (A+0+1).
    always_comb begin
        add_sel = ADD_OP_B;
        add_cin = 1'b0;
        if (T[T_SUB]) begin
            add_sel = ADD_OP_NOTB;
            add_cin = 1'b1;
        end else if (T[T_INC]) begin
            add_sel = ADD_OP_ZERO;
            add_cin = 1'b1;
        end
        case (add_sel)
            ADD_OP_B:    add_b = b_q;
            ADD_OP_NOTB: add_b = ~b_q;
            default:     add_b = '0;
        endcase
    end

    addsub_adder #(
        .W(WIDTH)
    ) u_adder (
        .a_i    (a_q),
        .b_i    (add_b),
        .cin_i  (add_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        as_d   = as_q;
        a_d    = a_q;
        bs_d   = bs_q;
        b_d    = b_q;
        e_d    = e_q;
        avf_d  = avf_q;
        done_d = 1'b0;
        err_d  = err_q;

        if (T != '0 && !strobe_ok) begin
            // Conflicting strobes: freeze the datapath, latch the violation.
            err_d = 1'b1;
        end else if (strobe_ok) begin
            if (T[T_IDLE] && load) begin
                as_d  = a_in[WIDTH];
                a_d   = a_in[WIDTH-1:0];
                bs_d  = b_in[WIDTH];
                b_d   = b_in[WIDTH-1:0];
                e_d   = 1'b0;
                avf_d = 1'b0;
            end
            if (T[T_NEGB]) begin
                bs_d = ~bs_q;
            end
            if (T[T_ADD]) begin
                a_d    = add_sum;
                e_d    = add_cout;
                avf_d  = add_cout;
                done_d = 1'b1;
            end
            if (T[T_SUB]) begin
                a_d   = add_sum;
                e_d   = add_cout;
                avf_d = 1'b0;
            end
            if (T[T_CHECK] && e_q) begin
                done_d = 1'b1;
`ifdef ADDSUB_ZERO_FIX_EN
                if (a_q == '0) begin
                    as_d = 1'b0;
                end
`endif
            end
            if (T[T_COMP]) begin
                a_d = ~a_q;
            end
            if (T[T_INC]) begin
                a_d    = add_sum;
                as_d   = ~as_q;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            as_q   <= 1'b0;
            a_q    <= '0;
            bs_q   <= 1'b0;
            b_q    <= '0;
            e_q    <= 1'b0;
            avf_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            as_q   <= as_d;
            a_q    <= a_d;
            bs_q   <= bs_d;
            b_q    <= b_d;
            e_q    <= e_d;
            avf_q  <= avf_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign S          = as_q ^ bs_q;
    assign E          = e_q;
    assign result     = {as_q, a_q};
    assign ovf        = avf_q;
    assign done       = done_q;
    assign onehot_err = err_q;

endmodule

// File: tb/tb_addsub_datapath.sv
// Scoreboard bench for addsub_datapath: a control sequencer issues strobes, a
// sign-magnitude arithmetic model predicts results, a monitor checks each done.
module tb_addsub_datapath;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [7:0]   T = 8'h00;
    logic         load = 1'b0;
    logic [W:0]   a_in = '0;
    logic [W:0]   b_in = '0;
    logic         S, E, ovf, done, onehot_err;
    logic [W:0]   result;

    typedef struct {
        logic [W:0] res;
        logic       e;
        logic       ovf;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    addsub_datapath #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .T          (T),
        .load       (load),
        .a_in       (a_in),
        .b_in       (b_in),
        .S          (S),
        .E          (E),
        .result     (result),
        .ovf        (ovf),
        .done       (done),
        .onehot_err (onehot_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Sign-magnitude arithmetic on integers: what the operation should yield.
    function automatic exp_t model(input logic [W:0] a, input logic [W:0] b, input bit sub, input string tag);
        exp_t r;
        int   ma = int'(a[W-1:0]);
        int   mb = int'(b[W-1:0]);
        bit   sa = a[W];
        bit   sb = b[W] ^ sub;
        int   mag;
        bit   sgn;
        r.tag = tag;
        if (sa == sb) begin
            mag   = ma + mb;
            r.e   = (mag >= (1 << W));
            r.ovf = r.e;
            sgn   = sa;
            mag   = mag % (1 << W);
        end else if (ma >= mb) begin
            mag   = ma - mb;
            r.e   = 1'b1;
            r.ovf = 1'b0;
            sgn   = sa;
`ifdef ADDSUB_ZERO_FIX_EN
            if (mag == 0) sgn = 1'b0;
`endif
        end else begin
            mag   = mb - ma;
            r.e   = 1'b0;
            r.ovf = 1'b0;
            sgn   = ~sa;
        end
        r.res = {sgn, mag[W-1:0]};
        return r;
    endfunction

    task automatic strobe(input logic [7:0] t);
        @(negedge clk);
        T    = t;
        load = 1'b0;
    endtask

    // Acts as the sequencing control unit; branches come from the bench's own view.
    task automatic run_op(input logic [W:0] a, input logic [W:0] b, input bit sub, input string tag);
        exp_t r;
        bit   s_exp;
        r     = model(a, b, sub, tag);
        s_exp = a[W] ^ b[W] ^ sub;
        @(negedge clk);
        a_in = a;
        b_in = b;
        load = 1'b1;
        T    = 8'h01;
        if (sub) strobe(8'h02);
        strobe(8'h04);
        chk({tag, " S at T2"}, 32'(S), 32'(s_exp));
        if (!s_exp) begin
            exp_q.push_back(r);
            strobe(8'h08);
        end else begin
            strobe(8'h10);
            if (a[W-1:0] >= b[W-1:0]) begin
                exp_q.push_back(r);
                strobe(8'h20);
            end else begin
                strobe(8'h20);
                strobe(8'h40);
                exp_q.push_back(r);
                strobe(8'h80);
            end
        end
        strobe(8'h00);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every done pulse must match the oldest outstanding prediction.
    initial begin
        exp_t r;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 required done=0 (result=%0h)", result);
                end else begin
                    r = exp_q.pop_front();
                    chk({r.tag, " result"}, 32'(result), 32'(r.res));
                    chk({r.tag, " E"},      32'(E),      32'(r.e));
                    chk({r.tag, " ovf"},    32'(ovf),    32'(r.ovf));
                    $display("op %s: result=%0h E=%0b ovf=%0b", r.tag, result, E, ovf);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W:0] ra, rb;
        bit         rs;

        #1;
        chk("reset result", 32'(result), 32'h0);
        chk("reset S",      32'(S),      32'h0);
        chk("reset E",      32'(E),      32'h0);
        chk("reset ovf",    32'(ovf),    32'h0);
        chk("reset done",   32'(done),   32'h0);
        chk("reset err",    32'(onehot_err), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_op(9'h005, 9'h003, 1'b0, "p5_add_p3");
        run_op(9'd200, 9'd100, 1'b0, "p200_add_p100");
        run_op(9'h005, 9'h003, 1'b1, "p5_sub_p3");
        run_op(9'h003, 9'h005, 1'b1, "p3_sub_p5");
        run_op(9'h105, 9'h005, 1'b0, "m5_add_p5");
        run_op(9'h0FF, 9'h0FF, 1'b0, "max_add_max");
        run_op(9'h000, 9'h000, 1'b1, "zero_sub_zero");
        run_op(9'h100, 9'h000, 1'b0, "mzero_add_pzero");
        run_op(9'h1FF, 9'h001, 1'b1, "mmax_sub_p1");

        for (int i = 0; i < 40; i++) begin
            ra = 9'($urandom_range(0, 511));
            rb = (i % 8 == 0) ? ra : 9'($urandom_range(0, 511));
            rs = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, $sformatf("rand%0d", i));
        end

        // Load without T0 must be ignored.
        @(negedge clk);
        a_in = 9'h005; b_in = 9'h003; load = 1'b1; T = 8'h01;
        @(negedge clk);
        a_in = 9'h1AA; b_in = 9'h055; load = 1'b1; T = 8'h00;
        @(negedge clk);
        load = 1'b0;
        chk("load_without_T0 result", 32'(result), 32'h005);

        // Multi-hot strobe: sticky error, datapath frozen, no done.
        strobe(8'b0000_1100);
        strobe(8'h00);
        chk("multihot err",    32'(onehot_err), 32'h1);
        chk("multihot result", 32'(result),     32'h005);
        chk("multihot E",      32'(E),          32'h0);
        repeat (3) @(negedge clk);
        chk("multihot err sticky", 32'(onehot_err), 32'h1);
        $display("op multihot: err=%0b result=%0h", onehot_err, result);

        // Asynchronous reset in the middle of a subtraction.
        @(negedge clk);
        a_in = 9'h007; b_in = 9'h009; load = 1'b1; T = 8'h01;
        strobe(8'h02);
        strobe(8'h04);
        strobe(8'h10);
        #2 reset = 1'b0;
        #1;
        chk("midreset result", 32'(result),     32'h0);
        chk("midreset S",      32'(S),          32'h0);
        chk("midreset E",      32'(E),          32'h0);
        chk("midreset ovf",    32'(ovf),        32'h0);
        chk("midreset done",   32'(done),       32'h0);
        chk("midreset err",    32'(onehot_err), 32'h0);
        @(negedge clk);
        T = 8'h00;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_reset result", 32'(result), 32'h0);
        $display("op midreset: result=%0h err=%0b", result, onehot_err);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL missing_done: got %0d outstanding required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/addsub_datapath.md
ADDSUB_DATAPATH -- requirements
Module: addsub_datapath

Interface
REQ-001 Parameter WIDTH, default 8, magnitude width in bits; the sign bit is extra.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 T  input  8  one-hot timing strobes T[0]..T[7] from the sequencing control unit.
REQ-005 load  input  1  operand capture request, honoured only while T[0]=1.
REQ-006 a_in  input  WIDTH+1  operand A, sign at MSB, magnitude below.
REQ-007 b_in  input  WIDTH+1  operand B, same format.
REQ-008 S  output  1  As XOR Bs, combinational from the registers.
REQ-009 E  output  1  end-carry register.
REQ-010 result  output  WIDTH+1  {As, A}.
REQ-011 ovf  output  1  add-overflow flag (AVF).
REQ-012 done  output  1  one-cycle registered completion pulse.
REQ-013 onehot_err  output  1  sticky strobe-violation flag.

Function
REQ-014 Registers: As, A[WIDTH-1:0], Bs, B[WIDTH-1:0], E, AVF, done_r, err_r.
REQ-015 T[0] with load=1: {As,A}<=a_in, {Bs,B}<=b_in, E<=0, AVF<=0; load without T[0] is ignored.
REQ-016 T[1]: Bs<=~Bs; subtraction becomes addition of the negated operand.
REQ-017 T[2]: no register update; S is valid for control branching (S=0 takes the add path, S=1 takes the subtract path).
REQ-018 T[3]: {E,A}<=A+B at WIDTH+1 bits; AVF<=carry out.
REQ-019 T[4]: {E,A}<=A+~B+1 at WIDTH+1 bits; E=1 means A>=B; AVF<=0.
REQ-020 T[5]: no magnitude update; E is valid for control branching.
REQ-021 T[6]: A<=~A.
REQ-022 T[7]: A<=A+1 modulo 2^WIDTH; As<=~As.
REQ-023 done_r<=1 on the edge after any of: T[3]; T[5] with E=1; T[7]. Otherwise done_r<=0.
REQ-024 T all-zero: all registers hold, done_r<=0.
REQ-025 T with more than one bit set: no datapath register updates; err_r<=1 and stays set until reset.
REQ-026 Arithmetic is unsigned on magnitudes; carries beyond WIDTH+1 bits are discarded.

Reset
REQ-027 reset=0 asynchronously clears As, A, Bs, B, E, AVF, done_r and err_r.
REQ-028 Reset values: result=0, S=0, E=0, ovf=0, done=0, onehot_err=0.
REQ-029 Reset mid-operation abandons the operation; no done pulse follows the release of reset.

Configuration
REQ-030 Macro ADDSUB_ZERO_FIX_EN: when defined, at T[5] with E=1 and A==0, As<=0, so negative zero is never produced.
REQ-031 Without ADDSUB_ZERO_FIX_EN, As is untouched at T[5]; a zero magnitude keeps its prior sign.

Structure
REQ-032 Package addsub_pkg holds the WIDTH default and the strobe index constants T_IDLE=0 through T_INC=7.
REQ-033 One sub-module, addsub_adder: a WIDTH-bit adder with carry-in, producing sum and carry-out, shared by T[3], T[4] and T[7].

Verification (WIDTH=8)
REQ-034 Load +5/+3; T0,T2,T3 -> result=0_00000101+3=0_00001000, E=0, ovf=0, done pulses once.
REQ-035 Load +200/+100; T0,T2,T3 -> A=44, E=1, ovf=1, done pulses.
REQ-036 Load +5/+3; T0,T1,T2(S=1),T4,T5 -> A=2, E=1, result=0_00000010, done after T5.
REQ-037 Load +3/+5; T0,T1,T2,T4 -> A=254, E=0; T5,T6 -> A=1; T7 -> result=1_00000010, done pulses.
REQ-038 Load -5/+5; T0,T2(S=1),T4,T5 -> A=0, E=1; with ADDSUB_ZERO_FIX_EN result=0_00000000, without it result=1_00000000.
REQ-039 Drive T=8'b00001100 -> onehot_err=1 and stays 1, result unchanged; then assert reset=0 mid-operation -> all outputs 0 immediately.
